// File: rtl/prbs_if.sv
// Receive-side link to the PRBS checker: beat strobe, data, clear, status.
// Bit-error counter exists only with PRBS_CHK_BIT_ERR_EN.
interface prbs_if #(
    parameter int CNT_W = 16
);
    logic             ce;
    logic [7:0]       din;
    logic             clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHK_BIT_ERR_EN
    logic [CNT_W-1:0] bit_err_cnt;

    modport master (
        output ce, din, clr,
        input  locked, err, err_cnt, bit_err_cnt
    );
    modport slave (
        input  ce, din, clr,
        output locked, err, err_cnt, bit_err_cnt
    );
`else
    modport master (
        output ce, din, clr,
        input  locked, err, err_cnt
    );
    modport slave (
        input  ce, din, clr,
        output locked, err, err_cnt
    );
`endif
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit Galois LFSR (x^8+x^4+x^3+x^2+1).
// Optional bit-error counter: define PRBS_CHK_BIT_ERR_EN.
module prbs_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int CNT_W    = 16
) (
    input  logic   clk,
    input  logic   rst,
    prbs_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [3:0]       LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS_N = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0] MAXV   = '1;

    function automatic logic [7:0] step(input logic [7:0] s);
        step = {s[6], s[5], s[4], s[3] ^ s[7],
                s[2] ^ s[7], s[1] ^ s[7], s[0], s[7]};
    endfunction

    state_t           state;
    logic [7:0]       exp;
    logic [3:0]       mcnt;
    logic [3:0]       lcnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    logic       hit;
    logic       bad;
    logic [3:0] mcnt_inc;
    logic [3:0] lcnt_inc;

    assign hit      = (bus.din == exp);
    assign bad      = bus.ce && (state == LOCKED) && !hit;
    assign mcnt_inc = mcnt + 4'd1;
    assign lcnt_inc = lcnt + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HUNT;
            exp    <= 8'hFF;
            mcnt   <= 4'd0;
            lcnt   <= 4'd0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= bad;
            if (bus.ce) begin
                case (state)
                    HUNT: begin
                        if (bus.din != 8'h00) begin
                            exp   <= step(bus.din);
                            mcnt  <= 4'd0;
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (hit) begin
                            exp  <= step(bus.din);
                            mcnt <= mcnt_inc;
                            if (mcnt_inc == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                lcnt   <= 4'd0;
                            end
                        end else if (bus.din != 8'h00) begin
                            exp  <= step(bus.din);
                            mcnt <= 4'd0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: received data never reseeds once locked
                        exp <= step(exp);
                        if (hit) begin
                            lcnt <= 4'd0;
                        end else begin
                            lcnt <= lcnt_inc;
                            if (lcnt_inc == LOSS_N) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (bus.clr) begin
            err_cnt <= '0;
        end else if (bad && err_cnt != MAXV) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign bus.locked  = locked;
    assign bus.err     = err;
    assign bus.err_cnt = err_cnt;

`ifdef PRBS_CHK_BIT_ERR_EN
    logic [CNT_W-1:0] bit_err_cnt;
    logic [3:0]       pc;
    logic [CNT_W+3:0] bsum;

    assign pc   = 4'($countones(bus.din ^ exp));
    assign bsum = (CNT_W+4)'(bit_err_cnt) + (CNT_W+4)'(pc);

    // Partial add that overflows clamps rather than wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_err_cnt <= '0;
        end else if (bus.clr) begin
            bit_err_cnt <= '0;
        end else if (bad) begin
            bit_err_cnt <= (|bsum[CNT_W+3:CNT_W]) ? MAXV
                                                  : bsum[CNT_W-1:0];
        end
    end

    assign bus.bit_err_cnt = bit_err_cnt;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with an abstract reference model.
// Model state advances after each clock edge; outputs compared on negedge.
module tb_prbs_checker;
    localparam int CNT_W = 4;
    localparam int LOCKN = 4;
    localparam int LOSSN = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prbs_if #(.CNT_W(CNT_W)) bus ();

    prbs_checker #(
        .LOCK_CNT(LOCKN),
        .LOSS_CNT(LOSSN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 searching, 1 verifying, 2 locked
    int         m_mode = 0;
    logic [7:0] m_exp  = 8'hFF;
    int         m_run  = 0;
    int         m_err  = 0;
    int         m_cnt  = 0;
    int         m_bcnt = 0;
    logic [7:0] tx;

    // next LFSR value as multiply-by-x modulo the polynomial
    function automatic logic [7:0] mstep(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], 1'b0};
        return b[7] ? (t ^ 8'h1D) : t;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_exp  = 8'hFF;
        m_run  = 0;
        m_err  = 0;
        m_cnt  = 0;
        m_bcnt = 0;
    endtask

    task automatic model_beat(input logic ce, input logic [7:0] d, input logic k);
        bit miss;
        int pc;
        miss  = 1'b0;
        pc    = $countones(d ^ m_exp);
        m_err = 0;
        if (ce) begin
            if (m_mode == 0) begin
                if (d != 8'h00) begin
                    m_mode = 1;
                    m_run  = 0;
                    m_exp  = mstep(d);
                end
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_run++;
                    m_exp = mstep(d);
                    if (m_run == LOCKN) begin
                        m_mode = 2;
                        m_run  = 0;
                    end
                end else if (d != 8'h00) begin
                    m_run = 0;
                    m_exp = mstep(d);
                end else begin
                    m_mode = 0;
                end
            end else begin
                miss  = (d != m_exp);
                m_exp = mstep(m_exp);
                if (miss) begin
                    m_err = 1;
                    m_run++;
                    if (m_run == LOSSN) m_mode = 0;
                end else begin
                    m_run = 0;
                end
            end
        end
        if (k) begin
            m_cnt  = 0;
            m_bcnt = 0;
        end else if (miss) begin
            m_cnt  = sat(m_cnt + 1);
            m_bcnt = sat(m_bcnt + pc);
        end
    endtask

    always @(negedge clk) begin
        check("locked", int'(bus.locked), (m_mode == 2) ? 1 : 0);
        check("err", int'(bus.err), m_err);
        check("err_cnt", int'(bus.err_cnt), m_cnt);
`ifdef PRBS_CHK_BIT_ERR_EN
        check("bit_err_cnt", int'(bus.bit_err_cnt), m_bcnt);
`endif
    end

    task automatic beat(input logic [7:0] d, input logic c = 1'b1,
                        input logic k = 1'b0);
        bus.ce  = c;
        bus.din = d;
        bus.clr = k;
        @(posedge clk);
        model_beat(c, d, k);
        #1;
        bus.ce  = 1'b0;
        bus.clr = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_locked", int'(bus.locked), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);
`ifdef PRBS_CHK_BIT_ERR_EN
        check("rst_bit_err_cnt", int'(bus.bit_err_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] seq [5];
    logic [7:0] rsd [4];

    initial begin
        bus.ce  = 1'b0;
        bus.din = 8'h00;
        bus.clr = 1'b0;
        seq = '{8'hFF, 8'hE3, 8'hDB, 8'hAB, 8'h4B};
        rsd = '{8'hAA, 8'h49, 8'h92, 8'h39};
        @(posedge clk);
        #1;
        pulse_reset();

        // lock on the reference sequence
        for (int i = 0; i < 5; i++) begin
            beat(seq[i]);
            if (i == 3) check("pre_lock", int'(bus.locked), 0);
        end
        check("lock", int'(bus.locked), 1);
        check("lock_err_cnt", int'(bus.err_cnt), 0);

        // single-bit error on 0x96, then 0x31 must match
        beat(8'h97);
        check("single_err", int'(bus.err), 1);
        check("single_err_cnt", int'(bus.err_cnt), 1);
        check("single_locked", int'(bus.locked), 1);
`ifdef PRBS_CHK_BIT_ERR_EN
        check("single_bit_cnt", int'(bus.bit_err_cnt), 1);
`endif
        beat(8'h31);
        check("recover_err", int'(bus.err), 0);
        check("recover_err_cnt", int'(bus.err_cnt), 1);

        // lock loss after eight zero bytes
        for (int i = 0; i < 8; i++) begin
            beat(8'h00);
            if (i == 6) check("loss_hold", int'(bus.locked), 1);
        end
        check("loss_locked", int'(bus.locked), 0);
        check("loss_err_cnt", int'(bus.err_cnt), 9);

        // zeros ignored in hunt, reseed on 0x55
        beat(8'h00);
        beat(8'h00);
        beat(8'hFF);
        beat(8'hE3);
        beat(8'h55);
        for (int i = 0; i < 4; i++) begin
            beat(rsd[i]);
            if (i == 2) check("reseed_pre", int'(bus.locked), 0);
        end
        check("reseed_lock", int'(bus.locked), 1);
        check("reseed_err_cnt", int'(bus.err_cnt), 9);
        tx = 8'h72;

        // clear, then saturate with interleaved errors
        beat(tx, 1'b1, 1'b1);
        tx = mstep(tx);
        check("clr", int'(bus.err_cnt), 0);
        for (int i = 0; i < 20; i++) begin
            beat(tx ^ 8'h01);
            tx = mstep(tx);
            beat(tx);
            tx = mstep(tx);
        end
        check("sat_err_cnt", int'(bus.err_cnt), 15);
        check("sat_locked", int'(bus.locked), 1);
`ifdef PRBS_CHK_BIT_ERR_EN
        check("sat_bit_cnt", int'(bus.bit_err_cnt), 15);
`endif
        beat(tx ^ 8'hFF, 1'b1, 1'b1);
        tx = mstep(tx);
        check("clr_prio_cnt", int'(bus.err_cnt), 0);
        check("clr_prio_err", int'(bus.err), 1);
        beat(tx ^ 8'hFF);
        tx = mstep(tx);
        beat(tx ^ 8'hFF);
        tx = mstep(tx);
        check("two_err_cnt", int'(bus.err_cnt), 2);
        check("two_err_level", int'(bus.err), 1);
`ifdef PRBS_CHK_BIT_ERR_EN
        check("bit_clamp", int'(bus.bit_err_cnt), 15);
`endif

        // lock with random idle gaps
        @(posedge clk);
        #1;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) beat(8'($urandom), 1'b0);
            beat(seq[i]);
        end
        repeat (2) beat(8'($urandom), 1'b0);
        check("gap_lock", int'(bus.locked), 1);
        check("gap_err_cnt", int'(bus.err_cnt), 0);

        // reset mid-stream after an error
        beat(8'h86);
        check("pre_rst_cnt", int'(bus.err_cnt), 1);
        pulse_reset();
        for (int i = 0; i < 4; i++) beat(seq[i]);
        check("relock_pending", int'(bus.locked), 0);
        beat(seq[4]);
        check("relock", int'(bus.locked), 1);

        repeat (2) beat(8'h00, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Byte-wide checker for the 8-bit Galois LFSR pattern produced by the team's `rnd` generator (taps x^8+x^4+x^3+x^2+1). It sits at the receive end of the link, after the differential Manchester decoder. Each valid received byte is compared against the locally predicted next LFSR state, so the checker self-synchronises to the incoming sequence. It reports lock status and error counts for link bring-up and bit-error-rate measurement.

## Interface
- `LOCK_CNT`, default 4: number of consecutive matching beats after the seed beat required to declare lock (range 1..15).
- `LOSS_CNT`, default 8: number of consecutive mismatching beats in LOCKED that cause lock loss (range 1..15).
- `CNT_W`, default 16: width of the error counters.
- `clk` input 1: clock.
- `rst` input 1: reset, asynchronous, active-high.
- `ce` input 1: `din` valid this cycle (one beat).
- `din` input 8: received LFSR state byte.
- `clr` input 1: synchronous clear of the error counters.
- `locked` output 1: registered; 1 while in LOCKED.
- `err` output 1: registered one-cycle pulse per mismatching beat in LOCKED.
- `err_cnt` output CNT_W: count of mismatching beats in LOCKED; saturating.
- `bit_err_cnt` output CNT_W: count of mismatching bits in LOCKED; saturating. Present only with `PRBS_CHK_BIT_ERR_EN`.

## Operation
- The step function `nx = step(s)` is defined as follows:
  - nx[0]=s[7], nx[1]=s[0], nx[2]=s[1]^s[7], nx[3]=s[2]^s[7], nx[4]=s[3]^s[7], nx[5]=s[4], nx[6]=s[5], nx[7]=s[6].
  - Reference sequence: FF→E3→DB→AB→4B.
- Internal state:
  - `exp[7:0]`: expected byte.
  - `mcnt`: 4-bit consecutive-match counter.
  - `lcnt`: 4-bit consecutive-miss counter.
  - FSM state: HUNT / SYNC / LOCKED.
- Beats with `ce`=0 change nothing. All transitions below occur on `ce`=1 beats.
- HUNT:
  - If `din`≠0x00: `exp`<=step(`din`), `mcnt`<=0, go to SYNC.
  - If `din`=0x00 (the LFSR lock-up state): ignored, stay in HUNT.
- SYNC:
  - On a match (`din`=`exp`): `exp`<=step(`din`) and `mcnt`++. When `mcnt`+1=LOCK_CNT, go to LOCKED with `lcnt`<=0.
  - On a mismatch: reseed. If `din`≠0, `exp`<=step(`din`), `mcnt`<=0, stay in SYNC. If `din`=0, go to HUNT.
  - No errors are counted in SYNC.
- LOCKED:
  - `exp`<=step(`exp`) on every beat (flywheel; the received byte is never used as a seed).
  - On a match: `lcnt`<=0.
  - On a mismatch: `err` pulses, `err_cnt` saturating +1, `lcnt`++. When `lcnt`+1=LOSS_CNT, go to HUNT and `locked` drops.
- Counters saturate at all-ones and never wrap.
- `clr` zeroes both counters and has priority over a simultaneous increment (result 0). `clr` does not affect the FSM or `err`.
- Reset values: FSM=HUNT, `exp`=0xFF, `mcnt`=0, `lcnt`=0, `locked`=0, `err`=0, `err_cnt`=0, `bit_err_cnt`=0.
- Asserting `rst` mid-stream returns the block to reset values immediately. Relock then requires a fresh seed plus LOCK_CNT matches.

## Timing
- Latency is one cycle: `err`, `locked` and the counters update on the clock edge that samples the beat, and are visible the following cycle.
- `locked` rises in the cycle after the LOCK_CNT-th matching beat. It falls in the cycle after the LOSS_CNT-th consecutive miss.
- `err` is high for exactly one cycle per erroneous beat. Back-to-back erroneous beats give a continuous high level.
- `ce` may be asserted every cycle. The design has no throughput limit and no backpressure.

## Configuration
- `PRBS_CHK_BIT_ERR_EN` defined:
  - `bit_err_cnt` port exists.
  - On each erroneous LOCKED beat it adds popcount(`din`^`exp`) (0..8), saturating. A partial add that would overflow clamps to all-ones.
  - `clr` clears it as well.
- Not defined: the port and its logic are absent. Only byte-level `err_cnt` is provided.

## Test plan
- Lock: after reset, feed FF,E3,DB,AB,4B on consecutive cycles (LOCK_CNT=4) -> `locked`=1 in the cycle after 4B; `err_cnt`=0.
- Single error: while locked, replace one byte with byte^0x01 -> one `err` pulse; `err_cnt`=1; `bit_err_cnt`=1 (macro on); `locked` stays 1; the next correct byte matches.
- Zero seed and reseed: feed 00,00 -> stays in HUNT. Then FF,E3,55 -> returns to SYNC reseeded on 55; lock requires 4 matches after 55.
- Lock loss: while locked, feed 8 bytes of 0x00 -> `err_cnt`=8, `locked` falls after the 8th; the state returns to HUNT.
- Saturation and clear: with CNT_W=4, inject 20 errors while keeping `lcnt`<LOSS_CNT by interleaving correct bytes -> `err_cnt`=15. Pulse `clr` together with an error -> `err_cnt`=0.
- Gaps and reset: lock with `ce` toggling randomly -> same result as gapless. Assert `rst` mid-stream -> `locked`=0 and counters=0 immediately.
